// File: rtl/iob_ethoc_wb_bridge_pkg.sv
// Shared definitions for the IOb -> Wishbone bridge in front of the ethmac
// register port: FSM state encoding and the data returned on a bus timeout.
package iob_ethoc_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for an IOb request
        ST_WB   = 2'd1,   // Wishbone cycle in progress
        ST_RESP = 2'd2    // one-cycle ready pulse back to the initiator
    } bridge_state_t;

    // Read data returned when the watchdog ends a cycle nobody acknowledged.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/iob_ethoc_wdog.sv
// Bus watchdog: counts enabled cycles after a clear and flags expiry once the
// count reaches TIMEOUT-1. The count saturates there and never wraps.
module iob_ethoc_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int                CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cycle counter: cleared on entry to the bus cycle, held at LAST once reached.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/iob_ethoc_wb_bridge.sv
// IOb native-bus responder that turns each access into one classic Wishbone
// single cycle toward the ethmac register port. One access outstanding at a
// time; a watchdog forces completion if the slave never answers.
module iob_ethoc_wb_bridge
    import iob_ethoc_wb_bridge_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int WB_ADR_W = 10,
    parameter int TIMEOUT  = 256
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    // IOb responder side
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                err_o,
    // Wishbone initiator side
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    bridge_state_t     state_q, state_d;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d;
    logic              resp_d;
    logic              accept;
    logic              expire;

    // Byte-lane bits and any bits above the ethmac window do not select a register.
    logic unused_addr;
    assign unused_addr = ^address;

    assign accept = (state_q == ST_IDLE) && valid;

    iob_ethoc_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clear    (accept),
        .enable   (state_q == ST_WB),
        .expire   (expire)
    );

    // Next-state and response selection; slave error outranks ack, ack outranks timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d = state_q;
        rdata_d = rdata;
        err_d   = 1'b0;
        resp_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (valid) state_d = ST_WB;
            end
            ST_WB: begin
                if (wb_err_i) begin
                    state_d = ST_RESP;
                    resp_d  = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    state_d = ST_RESP;
                    resp_d  = 1'b1;
                    rdata_d = wb_we_o ? '0 : wb_dat_i;
                end else if (expire) begin
                    state_d = ST_RESP;
                    resp_d  = 1'b1;
                    rdata_d = DATA_W'(TIMEOUT_RDATA);
                    err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and registered bus outputs; request fields latch only on acceptance.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= ST_IDLE;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            rdata    <= '0;
            ready    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_cyc_o <= (state_d == ST_WB);
            wb_stb_o <= (state_d == ST_WB);
            ready    <= resp_d;
            err_o    <= err_d;
            rdata    <= rdata_d;
            if (accept) begin
                wb_adr_o <= address[WB_ADR_W+1:2];
                wb_dat_o <= wdata;
                wb_sel_o <= (wstrb == '0) ? {(DATA_W/8){1'b1}} : wstrb;
                wb_we_o  <= (wstrb != '0);
            end
        end
    end

endmodule

// File: tb/tb_iob_ethoc_wb_bridge.sv
// Directed self-checking bench for iob_ethoc_wb_bridge with a hand-driven
// Wishbone slave and a short watchdog (TIMEOUT=16).
module tb_iob_ethoc_wb_bridge;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int WB_ADR_W = 10;
    localparam int TIMEOUT  = 16;

    logic                clk_i = 1'b0;
    logic                arst_n_i;
    logic                valid;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                ready;
    logic                err_o;
    logic [WB_ADR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0]   wb_dat_o;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic                wb_we_o;
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic [DATA_W-1:0]   wb_dat_i;
    logic                wb_ack_i;
    logic                wb_err_i;

    localparam logic [31:0] IDLE_DAT = 32'hCAFE0000;

    int n_checks = 0;
    int n_pass   = 0;

    iob_ethoc_wb_bridge #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WB_ADR_W (WB_ADR_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .valid    (valid),
        .address  (address),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .ready    (ready),
        .err_o    (err_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One IOb access; the slave answers in cycle valid+1+waits (if ack or err).
    task automatic run_access(input string tag, input logic [11:0] addr, input logic [31:0] wd,
                              input logic [3:0] ws, input int waits, input logic [31:0] sdat,
                              input logic ack, input logic err, input logic extra_valid,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input logic [9:0] exp_adr);
        int   n;
        int   cyc_cycles;
        int   late_ready;
        int   late_cyc;
        logic got_ready;
        logic [3:0] exp_sel;
        exp_sel = (ws == 4'h0) ? 4'hF : ws;
        valid   = 1'b1;
        address = addr;
        wdata   = wd;
        wstrb   = ws;
        tick();
        valid   = 1'b0;
        check({tag, ".cyc"}, 32'(wb_cyc_o), 32'd1);
        check({tag, ".stb"}, 32'(wb_stb_o), 32'd1);
        check({tag, ".adr"}, 32'(wb_adr_o), 32'(exp_adr));
        check({tag, ".sel"}, 32'(wb_sel_o), 32'(exp_sel));
        check({tag, ".we"},  32'(wb_we_o),  32'(ws != 4'h0));
        check({tag, ".dat"}, wb_dat_o, wd);
        n          = 1;
        cyc_cycles = 0;
        got_ready  = 1'b0;
        while (!got_ready && n <= 64) begin
            if (wb_cyc_o) cyc_cycles++;
            if (n == 1 && extra_valid) begin
                valid   = 1'b1;
                address = 12'h3FC;
                wdata   = 32'h55AA55AA;
                wstrb   = 4'h0;
            end
            if (n == waits + 1 && (ack || err)) begin
                wb_ack_i = ack;
                wb_err_i = err;
                wb_dat_i = sdat;
            end
            tick();
            n++;
            valid    = 1'b0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = IDLE_DAT;
            got_ready = ready;
        end
        check({tag, ".latency"},    32'(n), 32'(exp_lat));
        check({tag, ".cyc_cycles"}, 32'(cyc_cycles), 32'(exp_lat - 1));
        check({tag, ".ready"},  32'(ready), 32'd1);
        check({tag, ".err"},    32'(err_o), 32'(exp_err));
        check({tag, ".rdata"},  rdata, exp_rdata);
        check({tag, ".cyc_off"}, 32'(wb_cyc_o), 32'd0);
        check({tag, ".adr_held"}, 32'(wb_adr_o), 32'(exp_adr));
        late_ready = 0;
        late_cyc   = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ready) late_ready++;
            if (wb_cyc_o) late_cyc++;
        end
        check({tag, ".no_extra_ready"}, 32'(late_ready), 32'd0);
        check({tag, ".no_extra_cyc"},   32'(late_cyc), 32'd0);
        check({tag, ".rdata_hold"}, rdata, exp_rdata);
    endtask

    initial begin
        int late_ready;
        arst_n_i = 1'b0;
        valid    = 1'b0;
        address  = '0;
        wdata    = '0;
        wstrb    = '0;
        wb_dat_i = IDLE_DAT;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        #1;
        check("reset.ready", 32'(ready), 32'd0);
        check("reset.err",   32'(err_o), 32'd0);
        check("reset.rdata", rdata, 32'd0);
        check("reset.cyc",   32'(wb_cyc_o), 32'd0);
        check("reset.stb",   32'(wb_stb_o), 32'd0);
        check("reset.we",    32'(wb_we_o), 32'd0);
        check("reset.sel",   32'(wb_sel_o), 32'd0);
        check("reset.adr",   32'(wb_adr_o), 32'd0);
        check("reset.dat",   wb_dat_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;
        tick();

        // tag, addr, wdata, wstrb, waits, slave data, ack, err, extra valid, exp rdata, exp err, exp latency, exp adr
        run_access("wr_moder", 12'h000, 32'h0000A080, 4'hF, 2, 32'h0, 1'b1, 1'b0, 1'b0,
                   32'h0, 1'b0, 4, 10'h000);
        run_access("rd_moder", 12'h000, 32'h0, 4'h0, 0, 32'h0000A480, 1'b1, 1'b0, 1'b0,
                   32'h0000A480, 1'b0, 2, 10'h000);
        run_access("wr_604", 12'h604, 32'h00000080, 4'hF, 0, 32'h0, 1'b1, 1'b0, 1'b0,
                   32'h0, 1'b0, 2, 10'h181);
        run_access("wr_600", 12'h600, 32'h00108000, 4'hF, 1, 32'h0, 1'b1, 1'b0, 1'b0,
                   32'h0, 1'b0, 3, 10'h180);
        run_access("rd_timeout", 12'h010, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0,
                   32'hDEADBEEF, 1'b1, TIMEOUT + 1, 10'h004);
        run_access("rd_err_ack", 12'h008, 32'h0, 4'h0, 1, 32'h12345678, 1'b1, 1'b1, 1'b1,
                   32'h0, 1'b1, 3, 10'h002);
        run_access("wr_lowbits", 12'h00B, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 1'b1, 1'b0, 1'b0,
                   32'h0, 1'b0, 2, 10'h002);
        run_access("rd_after", 12'h044, 32'h0, 4'h0, 3, 32'h87654321, 1'b1, 1'b0, 1'b0,
                   32'h87654321, 1'b0, 5, 10'h011);

        // Slave ack/err while idle must not produce a response or disturb rdata.
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'hFFFFFFFF;
        late_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ready) late_ready++;
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = IDLE_DAT;
        check("idle_ack.ready", 32'(late_ready), 32'd0);
        check("idle_ack.rdata", rdata, 32'h87654321);

        // Reset in the middle of a Wishbone cycle.
        valid   = 1'b1;
        address = 12'h020;
        wdata   = 32'h0;
        wstrb   = 4'h0;
        tick();
        valid = 1'b0;
        check("rst_mid.cyc_before", 32'(wb_cyc_o), 32'd1);
        tick();
        arst_n_i = 1'b0;
        #1;
        check("rst_mid.cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_mid.stb", 32'(wb_stb_o), 32'd0);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        arst_n_i = 1'b1;
        late_ready = (ready ? 1 : 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ready) late_ready++;
        end
        check("rst_mid.no_ready", 32'(late_ready), 32'd0);
        run_access("post_rst", 12'h04C, 32'h00000001, 4'hF, 0, 32'h0, 1'b1, 1'b0, 1'b0,
                   32'h0, 1'b0, 2, 10'h013);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
